// File: rtl/thermo_level_ctrl.sv
// Ramp sequencer for the thermometer-code encoder: accepts a target level and
// walks the 4-bit level toward it one code per TICK_DIV cycles, with pause/abort.
module thermo_level_ctrl #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic [3:0] tgt_level,
    output logic       tgt_ready,
    input  logic       pause,
    input  logic       abort,
    output logic [3:0] level,
    output logic       busy,
    output logic       done
);

    // A divide-by-one prescaler still needs a one-bit register that stays at zero.
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    level_reg, level_next;
    logic [3:0]    target_reg, target_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          done_reg, done_next;

    logic          step_due;
    logic [3:0]    level_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            level_reg  <= 4'd0;
            target_reg <= 4'd0;
            presc_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            level_reg  <= level_next;
            target_reg <= target_next;
            presc_reg  <= presc_next;
            done_reg   <= done_next;
        end
    end

    assign step_due   = (presc_reg == PRESC_LAST);
    // Direction is latched at acceptance and the ramp stops on target, so
    // these increments can never wrap.
    assign level_step = (state_reg == UP) ? (level_reg + 4'd1) : (level_reg - 4'd1);

    always_comb begin
        state_next  = state_reg;
        level_next  = level_reg;
        target_next = target_reg;
        presc_next  = presc_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tgt_valid) begin
                    target_next = tgt_level;
                    presc_next  = '0;
                    if (tgt_level > level_reg) begin
                        state_next = UP;
                    end else if (tgt_level < level_reg) begin
                        state_next = DOWN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            UP, DOWN: begin
                // Abort outranks both pause and a step falling on the same edge.
                if (abort) begin
                    state_next = IDLE;
                    presc_next = '0;
                end else if (!pause) begin
                    if (step_due) begin
                        presc_next = '0;
                        level_next = level_step;
                        if (level_step == target_reg) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                presc_next = '0;
            end
        endcase
    end

    assign tgt_ready = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg == UP) || (state_reg == DOWN);
    assign level     = level_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_thermo_level_ctrl.sv
// Directed self-checking bench for thermo_level_ctrl with TICK_DIV = 4.
module tb_thermo_level_ctrl;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic [3:0] tgt_level;
    logic       tgt_ready;
    logic       pause;
    logic       abort;
    logic [3:0] level;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    thermo_level_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_level (tgt_level),
        .tgt_ready (tgt_ready),
        .pause     (pause),
        .abort     (abort),
        .level     (level),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", tgt_ready); end
        rst = 1'b0;
        #1;
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", tgt_ready); end
        $display("reset: level=%0d done=%b busy=%b ready=%b", level, done, busy, tgt_ready);
    endtask

    task automatic test_ramp_up();
        logic [3:0] exp_lvl;
        tgt_level = 4'd9; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_start: got %b want 1", busy); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL up_ready_start: got %b want 0", tgt_ready); end
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_lvl = 4'(k / 4);
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL up_level k=%0d: got %0d want %0d", k, level, exp_lvl); end
            checks++; if (done !== (k == 36)) begin errors++; $display("FAIL up_done k=%0d: got %b want %b", k, done, (k == 36)); end
            checks++; if (tgt_ready !== (k == 36)) begin errors++; $display("FAIL up_ready k=%0d: got %b want %b", k, tgt_ready, (k == 36)); end
            checks++; if (busy !== (k < 36)) begin errors++; $display("FAIL up_busy k=%0d: got %b want %b", k, busy, (k < 36)); end
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL up_done_clear: got %b want 0", done); end
        $display("ramp_up 0->9: level=%0d", level);
    endtask

    task automatic test_ramp_down();
        logic [3:0] exp_lvl;
        tgt_level = 4'd2; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            exp_lvl = 4'(9 - k / 4);
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL down_level k=%0d: got %0d want %0d", k, level, exp_lvl); end
            checks++; if (done !== (k == 28)) begin errors++; $display("FAIL down_done k=%0d: got %b want %b", k, done, (k == 28)); end
        end
        tick();
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL down_final: got %0d want 2", level); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL down_done_clear: got %b want 0", done); end
        $display("ramp_down 9->2: level=%0d", level);
    endtask

    task automatic test_equal_back_to_back();
        int n;
        tgt_level = 4'd5; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 12) begin errors++; $display("FAIL eq_setup_latency: got %0d want 12", n); end
        // New target offered in the done cycle: accepted on the very next edge.
        tgt_level = 4'd5; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL eq_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eq_busy: got %b want 0", busy); end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL eq_level: got %0d want 5", level); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL eq_ready: got %b want 1", tgt_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL eq_done_clear: got %b want 0", done); end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL eq_level_hold: got %0d want 5", level); end
        $display("equal 5->5: level=%0d", level);
    endtask

    task automatic test_pause();
        int n;
        int eff;
        logic [3:0] exp_lvl;
        tgt_level = 4'd0; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 20) begin errors++; $display("FAIL pause_setup_latency: got %0d want 20", n); end
        tick();
        tgt_level = 4'd15; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        eff = 0;
        for (int k = 1; k <= 63; k++) begin
            pause     = (k >= 11 && k <= 13);
            tgt_valid = (k == 20 || k == 21);
            tgt_level = 4'd3;
            tick();
            if (!pause) eff++;
            exp_lvl = 4'(eff / 4);
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL pause_level k=%0d: got %0d want %0d", k, level, exp_lvl); end
            checks++; if (done !== (k == 63)) begin errors++; $display("FAIL pause_done k=%0d: got %b want %b", k, done, (k == 63)); end
            checks++; if (busy !== (k < 63)) begin errors++; $display("FAIL pause_busy k=%0d: got %b want %b", k, busy, (k < 63)); end
        end
        pause = 1'b0; tgt_valid = 1'b0;
        tick();
        checks++; if (level !== 4'd15) begin errors++; $display("FAIL pause_final: got %0d want 15", level); end
        $display("pause 0->15: level=%0d", level);
    endtask

    task automatic test_abort();
        int n;
        logic [3:0] exp_lvl;
        tgt_level = 4'd0; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 80) begin tick(); n++; end
        checks++; if (n !== 60) begin errors++; $display("FAIL abort_setup_latency: got %0d want 60", n); end
        tick();
        tgt_level = 4'd12; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            tick();
            exp_lvl = 4'(k / 4);
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL abort_ramp k=%0d: got %0d want %0d", k, level, exp_lvl); end
        end
        // The edge below would otherwise step 6->7; abort must win.
        abort = 1'b1; pause = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (level !== 4'd6) begin errors++; $display("FAIL abort_level: got %0d want 6", level); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", tgt_ready); end
        tgt_level = 4'd3; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_new_busy: got %b want 1", busy); end
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 12) begin errors++; $display("FAIL abort_new_latency: got %0d want 12", n); end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL abort_new_level: got %0d want 3", level); end
        tick();
        $display("abort at 6 then 6->3: level=%0d", level);
    endtask

    task automatic test_reset_mid_ramp();
        int n;
        tgt_level = 4'd2; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 4) begin errors++; $display("FAIL rstmid_setup_latency: got %0d want 4", n); end
        tick();
        tgt_level = 4'd14; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL rstmid_pre_level: got %0d want 4", level); end
        rst = 1'b1;
        #1;
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b want 0", tgt_ready); end
        tick();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", tgt_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", done); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rstmid_level_hold: got %0d want 0", level); end
        $display("reset mid ramp 2->14: level=%0d busy=%b", level, busy);
    endtask

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_level = 4'd0;
        pause     = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_equal_back_to_back();
        test_pause();
        test_abort();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
